// File: rtl/soc_system_record_in_0.sv
// -----------------------------------------------------------------------------
// soc_system_record_in_0
//
// Debounced edge-capture input port with an Avalon-MM slave register interface.
// It is meant for slow, bouncy external signals such as a record button or a
// microphone-detect line. Each input bit goes through three stages:
//   1. A two-flop synchronizer.
//   2. A debounce counter. A new level is accepted only after it has been
//      stable for DEBOUNCE_CYCLES consecutive synchronized cycles.
//   3. Edge detection on the debounced level. A detected edge sets a sticky
//      capture bit.
// A level interrupt is raised while any unmasked capture bit is set.
//
// Parameters
//   WIDTH           number of input bits (1..32)
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level (1..65535)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//
// Ports
//   clk         single clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   address     Avalon-MM word address
//                 0 = stable level (read-only)
//                 1 = reads 0; writes are ignored
//                 2 = irq_mask (read/write)
//                 3 = edge_capture (read; write 1 to clear a bit)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits above WIDTH are ignored
//   in_port     asynchronous external inputs
//   readdata    combinational read data, zero-extended to 32 bits
//   irq         registered level interrupt: |(edge_capture & irq_mask)
// -----------------------------------------------------------------------------
module soc_system_record_in_0 #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. This width also leaves
  // room for DEBOUNCE_CYCLES itself, so the counter can never wrap.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STABLE  = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0] sync_meta;   // first synchronizer flop; may go metastable
  logic [WIDTH-1:0] sync;        // second synchronizer flop; safe to use
  logic [WIDTH-1:0] stable;      // debounced level
  logic [WIDTH-1:0] stable_d;    // stable delayed by one cycle, for edge detect
  logic [CNT_W-1:0] cnt [WIDTH]; // per-bit debounce counters
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] capture_clr;
  logic             wr_en;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments. Every flop then
  // samples pre-edge values, so the two synchronizer stages really are two
  // separate flops and do not collapse into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
      stable    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          // Any return to the accepted level restarts the count. This is
          // what makes short glitches invisible.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection on the debounced level
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks assign a default first. A path that leaves the
  // output unassigned would otherwise infer a latch.
  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0)      edge_hit = stable & ~stable_d;
    else if (EDGE_TYPE == 1) edge_hit = ~stable & stable_d;
    else                     edge_hit = stable ^ stable_d;
  end

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign wr_en       = chipselect & ~write_n;
  assign capture_clr = (wr_en && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d <= stable;
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      // The clear is applied before the set. A new edge therefore wins over
      // a write-1-to-clear of the same bit in the same cycle.
      edge_capture <= (edge_capture & ~capture_clr) | edge_hit;
      irq          <= |(edge_capture & irq_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: zero wait states and no side effects
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STABLE:  readdata[WIDTH-1:0] = stable;
      ADDR_MASK:    readdata[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_record_in_0.sv
// -----------------------------------------------------------------------------
// tb_soc_system_record_in_0
//
// Directed bench for soc_system_record_in_0. It uses two instances:
//   dut0  default parameters (WIDTH=1, DEBOUNCE_CYCLES=16, rising edge)
//   dut1  WIDTH=4, DEBOUNCE_CYCLES=4, falling edge
// Expected values are queued as each stimulus step is driven. They are popped
// in order as the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_soc_system_record_in_0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs1;
  logic [0:0]  in0;
  logic [3:0]  in1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  soc_system_record_in_0 dut0 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs0),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in0),
    .readdata   (rd0),
    .irq        (irq0)
  );

  soc_system_record_in_0 #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs1),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in1),
    .readdata   (rd1),
    .irq        (irq1)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL sb_underflow: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        mismatched++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd_check(input int which, input logic [1:0] a);
    address = a;
    #1;
    check(which == 0 ? rd0 : rd1);
  endtask

  task automatic irq_check(input int which);
    check({31'd0, (which == 0) ? irq0 : irq1});
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs0       = (which == 0);
    cs1       = (which == 1);
    tick();
    write_n   = 1'b1;
    cs0       = 1'b0;
    cs1       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; write_n = 1'b1; writedata = '0;
    cs0 = 1'b0; cs1 = 1'b0; in0 = '0; in1 = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    push("rst_stable", 0);  rd_check(0, 0);
    push("rst_mask", 0);    rd_check(0, 2);
    push("rst_capture", 0); rd_check(0, 3);
    push("rst_irq", 0);     irq_check(0);
    push("rst1_stable", 0); rd_check(1, 0);

    // A 10-cycle pulse is shorter than the 16-cycle debounce window
    in0 = 1'b1;
    for (int i = 0; i < 30; i++) push("glitch_stable", 0);
    push("glitch_capture", 0);
    push("glitch_irq", 0);
    tick(10);
    in0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rd_check(0, 0);
      tick();
    end
    rd_check(0, 3);
    irq_check(0);

    // Unmask bit 0. Writedata bits above WIDTH must be dropped.
    wr(0, 2, 32'hFFFF_FFFF);
    push("mask_rd", 1); rd_check(0, 2);

    // Clean step: stable at +18, capture at +19, irq at +20
    in0 = 1'b1;
    push("lat17_stable", 0);
    push("lat18_stable", 1);
    push("lat18_capture", 0);
    push("lat19_capture", 1);
    push("lat19_irq", 0);
    push("lat20_irq", 1);
    tick(17); rd_check(0, 0);
    tick();   rd_check(0, 0); rd_check(0, 3);
    tick();   rd_check(0, 3); irq_check(0);
    tick();   irq_check(0);

    // Write-1-to-clear: capture drops at once, irq one cycle later
    push("w1c_capture", 0);
    push("w1c_irq_hold", 1);
    push("w1c_irq", 0);
    wr(0, 3, 32'h1);
    rd_check(0, 3); irq_check(0);
    tick(); irq_check(0);

    // Falling edge is not captured for EDGE_TYPE 0
    in0 = 1'b0;
    push("fall_stable", 0);
    push("fall_capture", 0);
    tick(18); rd_check(0, 0); rd_check(0, 3);

    // A new edge and a clear on the same cycle: the set wins
    in0 = 1'b1;
    push("race_stable", 1);
    push("race_pre", 0);
    push("race_capture", 1);
    push("race_irq", 1);
    tick(18); rd_check(0, 0); rd_check(0, 3);
    wr(0, 3, 32'h1);
    rd_check(0, 3);
    tick(); irq_check(0);

    // Reset in the middle of a debounce aborts the count
    wr(0, 3, 32'h1);
    in0 = 1'b0;
    push("pre_rst_stable", 0);
    tick(18); rd_check(0, 0);
    in0 = 1'b1;
    tick(10);                       // counter sits at 8
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("mid_rst_stable", 0);
    push("mid_rst_mask", 0);
    push("mid_rst_capture", 0);
    push("mid_rst_irq", 0);
    push("mid_rst17_stable", 0);
    push("mid_rst18_stable", 1);
    push("mid_rst19_capture", 1);
    push("mid_rst_masked_irq", 0);
    rd_check(0, 0); rd_check(0, 2); rd_check(0, 3); irq_check(0);
    tick(17); rd_check(0, 0);
    tick();   rd_check(0, 0);
    tick();   rd_check(0, 3);
    tick();   irq_check(0);

    // WIDTH=4, DEBOUNCE_CYCLES=4 (latency 6), falling-edge capture
    in1 = 4'hF;
    push("w4_rise5", 0);
    push("w4_rise6", 32'hF);
    push("w4_rise_nocap", 0);
    tick(5); rd_check(1, 0);
    tick();  rd_check(1, 0);
    tick(2); rd_check(1, 3);

    in1 = 4'h6;                     // bits 3 and 0 fall
    push("w4_fall5", 32'hF);
    push("w4_fall6", 32'h6);
    push("w4_capture", 32'h9);
    push("w4_clr8", 32'h1);
    push("w4_addr1", 0);
    push("w4_addr1_wr", 0);
    push("w4_mask", 32'h5);
    push("w4_irq_pre", 0);
    push("w4_irq", 1);
    push("w4_irq_clr", 0);
    tick(5); rd_check(1, 0);
    tick();  rd_check(1, 0);
    tick();  rd_check(1, 3);
    wr(1, 3, 32'h8);
    rd_check(1, 3);
    rd_check(1, 1);
    wr(1, 1, 32'hFFFF_FFFF);
    rd_check(1, 1);
    wr(1, 2, 32'hFFFF_FFF5);
    rd_check(1, 2);
    irq_check(1);
    tick(); irq_check(1);
    wr(1, 3, 32'h1);
    tick(); irq_check(1);

    // Any expectation left unconsumed is itself a failure
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/soc_system_record_in_0.md
SOC_SYSTEM_RECORD_IN_0 -- requirements
Module: soc_system_record_in_0

Interface
REQ-001 Parameter WIDTH, default 1: number of input port bits, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a new level, 1..65535.
REQ-003 Parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port address, input, 2: Avalon-MM slave word address.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, WIDTH: asynchronous external inputs (record button, mic-detect).
REQ-011 Port readdata, output, 32: read data, zero-extended.
REQ-012 Port irq, output, 1: level interrupt request.

Function
REQ-013 Each in_port bit shall pass a two-flop synchronizer; sync value = second flop.
REQ-014 Per bit, a debounce counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits shall clear whenever sync equals the stable value and increment otherwise.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 while sync differs from stable, the stable bit shall take the sync value next cycle and the counter shall clear.
REQ-016 Counter shall never wrap; a glitch shorter than DEBOUNCE_CYCLES cycles shall not change stable.
REQ-017 Latency in_port change -> stable change: exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-018 Edge detect shall compare stable with its one-cycle delayed copy; edge type per EDGE_TYPE.
REQ-019 A detected edge shall set the corresponding edge_capture bit the cycle after stable changes.
REQ-020 Register map: addr 0 = stable (RO); addr 1 = reads 0, writes ignored; addr 2 = irq_mask (RW, WIDTH bits); addr 3 = edge_capture (read; write-1-to-clear per bit).
REQ-021 Write occurs when chipselect=1 and write_n=0; takes effect on next clk edge; writedata bits above WIDTH ignored.
REQ-022 Simultaneous edge set and write-1-clear on same bit: set wins (bit remains 1).
REQ-023 readdata shall be combinational from address and current registers, zero wait states, bits [31:WIDTH] = 0.
REQ-024 Reads shall have no side effects.
REQ-025 irq shall be registered: irq <= |(edge_capture & irq_mask), i.e. one cycle after capture or mask change.

Reset
REQ-026 On reset=1 at a clk edge: synchronizer flops, stable, delayed copy, counters, irq_mask, edge_capture, irq all 0.
REQ-027 Reset asserted mid-debounce shall abort the count; no edge shall be captured for the reset cycle or the cycle following deassertion.
REQ-028 If in_port is high at reset release, stable shall rise after 2 + DEBOUNCE_CYCLES cycles and, with EDGE_TYPE 0 or 2, capture a rising edge.

Verification
REQ-029 DEBOUNCE_CYCLES=16, in_port 0->1 held -> addr 0 reads 1 exactly 18 cycles after change; addr 3 reads 1 one cycle later.
REQ-030 in_port pulse high 10 cycles (DEBOUNCE_CYCLES=16) -> addr 0 and addr 3 stay 0, irq stays 0.
REQ-031 Write addr 2 = 1, then capture edge -> irq = 1 one cycle after edge_capture sets; write addr 3 = 1 -> edge_capture 0, irq 0 next cycle.
REQ-032 Write addr 3 = 1 on same cycle a new edge sets bit 0 -> addr 3 reads 1 afterwards.
REQ-033 WIDTH=4, EDGE_TYPE=1, bits 3 and 0 fall -> addr 3 reads 0x9; write 0x8 -> reads 0x1; addr 1 reads 0.
REQ-034 Assert reset for 1 cycle at count 8 of a debounce -> all registers 0, count restarts, stable follows only after full 18 cycles.
